path_stack: RTL and testbench
=============================

Name: path_stack

Overview:
- Direction-history store that sits directly downstream of the maze solver.
- During search, the solver pushes one 2-bit direction per forward step and pops one per backtrack, so the stack always holds the current path from source to the rat's cell.
- After the solver raises done, a run request replays the stored path oldest-first (entry 0 upward), one move per accepted handshake, to the move consumer.
- Provides full/empty/count status and an error strobe for illegal push/pop.

Parameters:
- DEPTH, 256, number of direction entries (one per maze cell of a 16x16 maze).
- PTR_W, 8, pointer/count width; count range 0..DEPTH (the extra bit comes from count being PTR_W+1 wide).
- DIR_W, 2, direction code width (0=up, 1=right, 2=down, 3=left).

Ports:
- clk, in, 1, system clock, rising-edge.
- rst, in, 1, synchronous active-high reset.
- clear, in, 1, synchronous flush: count to 0, state to SEARCH.
- push, in, 1, write din at top.
- pop, in, 1, remove top entry.
- din, in, DIR_W, direction to push.
- top_dir, out, DIR_W, combinational read of entry count-1; 0 when empty.
- run, in, 1, start replay (level or pulse, sampled in SEARCH only).
- move_valid, out, 1, replay output valid.
- move_ready, in, 1, consumer accepts move.
- move_dir, out, DIR_W, replayed direction.
- replay_done, out, 1, high in DONE state.
- count, out, PTR_W+1, entries held.
- full, out, 1, count==DEPTH.
- empty, out, 1, count==0.
- err, out, 1, one-cycle strobe on illegal op.

Behaviour:
- Reset (rst=1 at a clk edge, dominates every other input): state=SEARCH, count=0, rd_ptr=0, move_valid=0, move_dir=0, replay_done=0, err=0. Memory contents are not cleared.
- States: SEARCH, REPLAY, DONE.
- SEARCH, per edge:
  - push only, not full: mem[count]<=din, count+1.
  - pop only, not empty: count-1.
  - push&pop, not empty: mem[count-1]<=din, count unchanged (replace top).
  - push&pop when empty: treated as a push.
  - push when full (push only): ignored, err=1 next cycle.
  - pop when empty (pop only): ignored, err=1 next cycle.
  - run=1 and no push/pop: go to REPLAY, rd_ptr<=0. If count==0, go directly to DONE instead.
  - run together with push or pop: the push/pop executes and run is ignored that cycle.
- REPLAY:
  - move_valid=1 and move_dir=mem[rd_ptr], registered; first valid one cycle after run is sampled.
  - A transfer occurs on an edge where move_valid&move_ready=1.
  - On transfer: rd_ptr+1, next entry presented the following cycle, so one move per cycle under continuous ready.
  - On transfer of entry count-1: move_valid<=0, state to DONE.
  - move_dir/move_valid held stable while ready=0.
  - push, pop and run are ignored (no err) in REPLAY and DONE.
- DONE: replay_done=1, move_valid=0. Stays until clear or rst.
- clear (any state, lower priority than rst): count=0, rd_ptr=0, move_valid=0, replay_done=0, state SEARCH. Simultaneous push/pop/run are ignored.
- Stack contents are untouched by replay, so a path can be re-read only after re-pushing; replay is not re-armable without clear.
- full, empty and count are registered-state derived (no combinational path from push/pop).
- err is asserted only for the cycle after the offending edge.

Test Plan:
- Reset then push dirs 1,1,2,3 on 4 consecutive cycles -> count=4, top_dir=3, empty=0, full=0, err never asserted.
- After previous: pop twice, then push&pop together with din=0 -> count=2, top_dir=0, entries {1,0}.
- With stack {1,1,2,3}, pulse run, move_ready=1 -> move_valid high for 4 consecutive cycles starting 1 cycle after run, move_dir 1,1,2,3; replay_done=1 on the following cycle.
- Same replay with move_ready low on the 2nd and 3rd valid cycles -> move_dir held at 1, total 4 transfers, order unchanged, no duplicates.
- Pop on empty -> err=1 for one cycle, count stays 0. Fill 256 pushes then push again -> full=1, err pulse, count=256.
- run with count=0 -> replay_done=1 next cycle, move_valid never high. Then clear -> replay_done=0, SEARCH. Assert rst mid-REPLAY -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/path_stack_if.sv
// Handshake/status bundle between the maze solver / move consumer and the
// path_stack direction-history store.
interface path_stack_if #(
  parameter int DIR_W = 2,
  parameter int PTR_W = 8
);
  // Stack control from the solver
  logic             clear;
  logic             push;
  logic             pop;
  logic [DIR_W-1:0] din;
  logic [DIR_W-1:0] top_dir;

  // Replay handshake towards the move consumer
  logic             run;
  logic             move_valid;
  logic             move_ready;
  logic [DIR_W-1:0] move_dir;
  logic             replay_done;

  // Status
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             err;

  // Solver/consumer side
  modport master (
    output clear, push, pop, din, run, move_ready,
    input  top_dir, move_valid, move_dir, replay_done, count, full, empty, err
  );

  // Stack side
  modport slave (
    input  clear, push, pop, din, run, move_ready,
    output top_dir, move_valid, move_dir, replay_done, count, full, empty, err
  );
endinterface

// File: rtl/path_stack.sv
// Direction-history stack for the maze solver. Holds the current path while
// searching, then replays it oldest-first over a valid/ready handshake.
module path_stack #(
  parameter int DEPTH = 256,
  parameter int PTR_W = 8,
  parameter int DIR_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  path_stack_if.slave  ps_if
);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_REPLAY = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e           state_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             move_valid_q;
  logic [DIR_W-1:0] move_dir_q;
  logic             replay_done_q;
  logic             err_q;

  logic [DIR_W-1:0] mem_q [DEPTH];

  // Status is derived purely from the registered count.
  logic full_w;
  logic empty_w;
  assign full_w  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_w = (count_q == '0);

  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] rd_next;
  logic             rd_last;
  logic             xfer;
  assign top_idx = PTR_W'(count_q - 1'b1);
  assign rd_next = rd_ptr_q + 1'b1;
  assign rd_last = ({1'b0, rd_ptr_q} == (count_q - 1'b1));
  assign xfer    = move_valid_q & ps_if.move_ready;

  // Stack operations are only honoured in SEARCH and never alongside clear.
  logic in_search;
  assign in_search = (state_q == S_SEARCH) && !ps_if.clear;

  logic             push_d;
  logic             replace_d;
  logic             pop_d;
  logic             run_d;
  logic             err_d;
  logic             mem_we_d;
  logic [PTR_W-1:0] mem_waddr_d;

  // Decode the push/pop/run request for this cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    push_d      = 1'b0;
    replace_d   = 1'b0;
    pop_d       = 1'b0;
    run_d       = 1'b0;
    err_d       = 1'b0;
    if (in_search) begin
      unique case ({ps_if.push, ps_if.pop})
        2'b10: begin
          if (full_w) err_d  = 1'b1;
          else        push_d = 1'b1;
        end
        2'b01: begin
          if (empty_w) err_d = 1'b1;
          else         pop_d = 1'b1;
        end
        2'b11: begin
          // Simultaneous push/pop replaces the top; on an empty stack it is a push.
          if (empty_w) push_d    = 1'b1;
          else         replace_d = 1'b1;
        end
        default: run_d = ps_if.run;
      endcase
    end
    mem_we_d    = (push_d | replace_d) & ~rst;
    mem_waddr_d = replace_d ? top_idx : PTR_W'(count_q);
  end

  // Direction storage: written on push/replace only.
  // NOTE: the memory array has no reset; its contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= ps_if.din;
    end
  end

  // Control FSM with registered replay outputs and error strobe.
  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_SEARCH;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      move_valid_q  <= 1'b0;
      move_dir_q    <= '0;
      replay_done_q <= 1'b0;
      err_q         <= 1'b0;
    end else if (ps_if.clear) begin
      state_q       <= S_SEARCH;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      move_valid_q  <= 1'b0;
      move_dir_q    <= '0;
      replay_done_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      err_q <= err_d;
      unique case (state_q)
        S_SEARCH: begin
          if (push_d)     count_q <= count_q + 1'b1;
          else if (pop_d) count_q <= count_q - 1'b1;
          if (run_d) begin
            rd_ptr_q <= '0;
            if (empty_w) begin
              state_q       <= S_DONE;
              replay_done_q <= 1'b1;
            end else begin
              state_q      <= S_REPLAY;
              move_valid_q <= 1'b1;
              move_dir_q   <= mem_q[0];
            end
          end
        end
        S_REPLAY: begin
          if (xfer) begin
            rd_ptr_q <= rd_next;
            if (rd_last) begin
              move_valid_q  <= 1'b0;
              state_q       <= S_DONE;
              replay_done_q <= 1'b1;
            end else begin
              move_dir_q <= mem_q[rd_next];
            end
          end
        end
        S_DONE: begin
          move_valid_q <= 1'b0;
        end
        default: begin
          state_q <= S_SEARCH;
        end
      endcase
    end
  end

  assign ps_if.top_dir     = empty_w ? '0 : mem_q[top_idx];
  assign ps_if.move_valid  = move_valid_q;
  assign ps_if.move_dir    = move_dir_q;
  assign ps_if.replay_done = replay_done_q;
  assign ps_if.count       = count_q;
  assign ps_if.full        = full_w;
  assign ps_if.empty       = empty_w;
  assign ps_if.err         = err_q;

endmodule

// File: tb/tb_path_stack.sv
// Self-checking bench for path_stack: a queue model of the stack predicts
// status after each operation, and a scoreboard checks replayed moves.
module tb_path_stack;

  localparam int DEPTH = 256;
  localparam int PTR_W = 8;
  localparam int DIR_W = 2;

  logic clk;
  logic rst;

  path_stack_if #(.DIR_W(DIR_W), .PTR_W(PTR_W)) ps ();

  path_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DIR_W(DIR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .ps_if (ps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DIR_W-1:0] stk[$];     // model of stack contents
  logic [DIR_W-1:0] exp_q[$];   // scoreboard of expected replay moves
  int               xfers;
  bit               stall_prev;
  logic [DIR_W-1:0] prev_dir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", ps.move_valid, 1);
        check("hold_dir", ps.move_dir, prev_dir);
      end
      if (ps.move_valid && ps.move_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_move", ps.move_valid, 0);
        end else begin
          logic [DIR_W-1:0] e;
          e = exp_q.pop_front();
          check("move_dir", ps.move_dir, e);
          xfers++;
        end
      end
      stall_prev = ps.move_valid && !ps.move_ready;
      prev_dir   = ps.move_dir;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, ps.count, stk.size());
    check({tag, "_top"}, ps.top_dir, (stk.size() == 0) ? 0 : stk[stk.size()-1]);
    check({tag, "_empty"}, ps.empty, stk.size() == 0);
    check({tag, "_full"}, ps.full, stk.size() == DEPTH);
  endtask

  // One stack operation in SEARCH with model prediction.
  task automatic op(input bit p, input bit q, input logic [DIR_W-1:0] d, input bit r);
    bit exp_err;
    exp_err = 1'b0;
    if (p && q && stk.size() > 0)        stk[stk.size()-1] = d;
    else if (p && stk.size() < DEPTH)    stk.push_back(d);
    else if (p && !q)                    exp_err = 1'b1;
    else if (q && stk.size() > 0)        void'(stk.pop_back());
    else if (q)                          exp_err = 1'b1;
    ps.push = p; ps.pop = q; ps.din = d; ps.run = r;
    tick();
    ps.push = 1'b0; ps.pop = 1'b0; ps.run = 1'b0;
    check("op_err", ps.err, exp_err);
    check_status("op");
    if (r) check("op_run_ignored", ps.move_valid, 0);
  endtask

  task automatic idle_check();
    tick();
    check("idle_err", ps.err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stk.delete();
    exp_q.delete();
  endtask

  task automatic do_clear();
    ps.clear = 1'b1;
    tick();
    ps.clear = 1'b0;
    stk.delete();
    exp_q.delete();
    check("clear_done", ps.replay_done, 0);
    check("clear_valid", ps.move_valid, 0);
    check("clear_count", ps.count, 0);
  endtask

  // Replay the modelled stack; sa/sb are valid-cycle indices with ready low.
  task automatic replay(input int sa, input int sb, input bit poke, input bit rnd, input int exp_iter);
    int n;
    int iters;
    n = stk.size();
    exp_q = stk;
    xfers = 0;
    ps.move_ready = 1'b1;
    ps.run = 1'b1;
    tick();
    ps.run = 1'b0;
    check("first_valid", ps.move_valid, 1);
    check("first_dir", ps.move_dir, stk[0]);
    iters = 0;
    while (!ps.replay_done && iters < 5000) begin
      ps.move_ready = rnd ? 1'($urandom_range(0, 1)) : ((iters != sa) && (iters != sb));
      if (poke && iters == 0) begin
        ps.push = 1'b1; ps.din = 2'd3;
      end
      tick();
      ps.push = 1'b0;
      if (poke && iters == 0) begin
        check("replay_push_err", ps.err, 0);
        check("replay_push_count", ps.count, n);
      end
      iters++;
    end
    ps.move_ready = 1'b1;
    check("replay_finished", ps.replay_done, 1);
    check("replay_valid_low", ps.move_valid, 0);
    check("replay_xfers", xfers, n);
    check("replay_sb_empty", exp_q.size(), 0);
    if (exp_iter >= 0) check("replay_cycles", iters, exp_iter);
  endtask

  initial begin
    rst = 1'b0;
    ps.clear = 1'b0; ps.push = 1'b0; ps.pop = 1'b0; ps.din = '0;
    ps.run = 1'b0; ps.move_ready = 1'b1;
    stall_prev = 1'b0;
    prev_dir = '0;
    xfers = 0;

    // Reset state
    do_reset();
    do_reset();
    check_status("rst");
    check("rst_err", ps.err, 0);
    check("rst_valid", ps.move_valid, 0);
    check("rst_dir", ps.move_dir, 0);
    check("rst_done", ps.replay_done, 0);

    // Push 1,1,2,3 then pop twice and replace top with 0 -> {1,0}
    op(1, 0, 2'd1, 0); op(1, 0, 2'd1, 0); op(1, 0, 2'd2, 0); op(1, 0, 2'd3, 0);
    check("push4_count", ps.count, 4);
    check("push4_top", ps.top_dir, 3);
    op(0, 1, 2'd0, 0); op(0, 1, 2'd0, 0); op(1, 1, 2'd0, 0);
    check("replace_count", ps.count, 2);
    check("replace_top", ps.top_dir, 0);
    replay(-1, -1, 0, 0, 2);

    // Continuous-ready replay of {1,1,2,3}
    do_clear();
    op(1, 0, 2'd1, 0); op(1, 0, 2'd1, 0); op(1, 0, 2'd2, 0); op(1, 0, 2'd3, 0);
    replay(-1, -1, 0, 0, 4);

    // Stalled replay, with an ignored push during REPLAY
    do_clear();
    op(1, 0, 2'd1, 0); op(1, 0, 2'd1, 0); op(1, 0, 2'd2, 0); op(1, 0, 2'd3, 0);
    replay(1, 2, 1, 0, 6);

    // Pop on empty, push&pop on empty, err strobe length
    do_clear();
    op(0, 1, 2'd0, 0);
    idle_check();
    check("empty_pop_count", ps.count, 0);
    op(1, 1, 2'd2, 0);
    op(0, 1, 2'd0, 0);

    // Fill to full, overflow push, then random-ready replay of all entries
    for (int i = 0; i < DEPTH; i++) op(1, 0, 2'($urandom_range(0, 3)), 0);
    check("fill_full", ps.full, 1);
    op(1, 0, 2'd1, 0);
    idle_check();
    check("overflow_count", ps.count, DEPTH);
    replay(-1, -1, 0, 1, -1);

    // Run with an empty stack goes straight to DONE
    do_clear();
    ps.run = 1'b1;
    tick();
    ps.run = 1'b0;
    check("zero_run_done", ps.replay_done, 1);
    check("zero_run_valid", ps.move_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("zero_run_valid_hold", ps.move_valid, 0);
      check("zero_run_done_hold", ps.replay_done, 1);
    end
    do_clear();

    // Run together with push: push executes, run ignored
    op(1, 0, 2'd2, 1);
    idle_check();
    check("run_push_done", ps.replay_done, 0);
    check("run_push_valid", ps.move_valid, 0);

    // Reset in the middle of a replay
    do_clear();
    op(1, 0, 2'd1, 0); op(1, 0, 2'd2, 0); op(1, 0, 2'd3, 0);
    exp_q = stk;
    xfers = 0;
    ps.run = 1'b1;
    tick();
    ps.run = 1'b0;
    check("mid_valid", ps.move_valid, 1);
    tick();
    do_reset();
    check_status("mid_rst");
    check("mid_rst_valid", ps.move_valid, 0);
    check("mid_rst_dir", ps.move_dir, 0);
    check("mid_rst_done", ps.replay_done, 0);
    check("mid_rst_err", ps.err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
